keccak_round_sequencer: RTL and testbench



---
 rtl/keccak_pkg.sv | 32 +++
 rtl/keccak_round_sequencer_if.sv | 32 +++
 rtl/keccak_round_sequencer.sv | 138 +++++++++++++
 tb/tb_keccak_round_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// ============================================================================
// keccak_pkg -- shared sizing and types for the Keccak-f[1600] round control
// Revision: 1.0
// ============================================================================
`default_nettype none

package keccak_pkg;

  localparam int ROUNDS    = 24;
  localparam int NUM_STEPS = ROUNDS / 2;
  localparam int STEP_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Shared with the round-constant generator's i1/i2 select inputs.
  typedef logic [NUM_STEPS-1:0] step_sel_t;
  typedef logic [STEP_W-1:0]    step_idx_t;

  function automatic step_sel_t sel_of_idx(input step_idx_t idx);
    step_sel_t sel;
    sel = '0;
    if (int'(idx) < NUM_STEPS) sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keccak_round_sequencer_if.sv
// ============================================================================
// keccak_round_sequencer_if -- sponge controller <-> round sequencer handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

interface keccak_round_sequencer_if;
  import keccak_pkg::*;

  logic      start_valid;
  logic      start_ready;
  logic      abort;
  step_sel_t round_sel;
  step_idx_t step_idx;
  logic      perm_first;
  logic      perm_en;
  logic      out_valid;
  logic      out_ready;

  modport master (
    output start_valid, abort, out_ready,
    input  start_ready, round_sel, step_idx, perm_first, perm_en, out_valid
  );

  modport slave (
    input  start_valid, abort, out_ready,
    output start_ready, round_sel, step_idx, perm_first, perm_en, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/keccak_round_sequencer.sv
// ============================================================================
// keccak_round_sequencer -- steps a one-hot double-round select through a
// Keccak-f[1600] permutation and hands the result back to the sponge FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module keccak_round_sequencer
  import keccak_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  keccak_round_sequencer_if.slave  seq
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  step_sel_t  r_round_sel;
  step_sel_t  w_sel_nxt;
  step_idx_t  r_step_idx;
  step_idx_t  w_idx_nxt;
  logic       r_perm_first;
  logic       w_first_nxt;
  logic       r_perm_en;
  logic       w_en_nxt;
  logic       r_out_valid;
  logic       w_ov_nxt;
  logic       w_start_ready;
  logic       w_accept;

  // Releasing a result and taking the next request on one edge avoids a bubble.
  assign w_start_ready = (r_state == IDLE) || ((r_state == DONE) && seq.out_ready);
  assign w_accept      = seq.start_valid && w_start_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_round_sel;
    w_idx_nxt   = r_step_idx;
    w_first_nxt = 1'b0;
    w_en_nxt    = r_perm_en;
    w_ov_nxt    = r_out_valid;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = RUN;
          w_sel_nxt   = step_sel_t'(1);
          w_idx_nxt   = '0;
          w_first_nxt = 1'b1;
          w_en_nxt    = 1'b1;
          w_ov_nxt    = 1'b0;
        end
      end

      RUN: begin
        if (seq.abort) begin
          w_state_nxt = IDLE;
          w_sel_nxt   = '0;
          w_idx_nxt   = '0;
          w_en_nxt    = 1'b0;
          w_ov_nxt    = 1'b0;
        end else if (r_round_sel[NUM_STEPS-1]) begin
          w_state_nxt = DONE;
          w_sel_nxt   = '0;
          w_idx_nxt   = '0;
          w_en_nxt    = 1'b0;
          w_ov_nxt    = 1'b1;
        end else begin
          w_sel_nxt   = {r_round_sel[NUM_STEPS-2:0], 1'b0};
          w_idx_nxt   = r_step_idx + step_idx_t'(1);
          w_en_nxt    = 1'b1;
        end
      end

      DONE: begin
        if (w_accept) begin
          w_state_nxt = RUN;
          w_sel_nxt   = step_sel_t'(1);
          w_idx_nxt   = '0;
          w_first_nxt = 1'b1;
          w_en_nxt    = 1'b1;
          w_ov_nxt    = 1'b0;
        end else if (seq.out_ready) begin
          w_state_nxt = IDLE;
          w_ov_nxt    = 1'b0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_sel_nxt   = '0;
        w_idx_nxt   = '0;
        w_en_nxt    = 1'b0;
        w_ov_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_round_sel  <= '0;
      r_step_idx   <= '0;
      r_perm_first <= 1'b0;
      r_perm_en    <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_round_sel  <= w_sel_nxt;
      r_step_idx   <= w_idx_nxt;
      r_perm_first <= w_first_nxt;
      r_perm_en    <= w_en_nxt;
      r_out_valid  <= w_ov_nxt;
    end
  end

  assign seq.start_ready = w_start_ready;
  assign seq.round_sel   = r_round_sel;
  assign seq.step_idx    = r_step_idx;
  assign seq.perm_first  = r_perm_first;
  assign seq.perm_en     = r_perm_en;
  assign seq.out_valid   = r_out_valid;

  a_sel_onehot : assert property (@(posedge clk) disable iff (reset)
    (r_state == RUN) ? $onehot(r_round_sel) : (r_round_sel == '0));

  a_idx_matches_sel : assert property (@(posedge clk) disable iff (reset)
    (r_state == RUN) ? (r_round_sel == sel_of_idx(r_step_idx)) : (r_step_idx == '0));

  a_first_implies_en : assert property (@(posedge clk) disable iff (reset)
    r_perm_first |-> r_perm_en);

  a_no_valid_while_running : assert property (@(posedge clk) disable iff (reset)
    !(r_out_valid && r_perm_en));

endmodule

`default_nettype wire

// File: tb/tb_keccak_round_sequencer.sv
// ============================================================================
// tb_keccak_round_sequencer -- cycle-by-cycle vector bench for the sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_keccak_round_sequencer;
  import keccak_pkg::*;

  typedef struct {
    bit        rst;
    bit        sv;
    bit        ab;
    bit        ordy;
    step_sel_t sel;
    step_idx_t idx;
    bit        first;
    bit        en;
    bit        ov;
    bit        sr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  keccak_round_sequencer_if bus ();

  keccak_round_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .seq   (bus.slave)
  );

  task automatic add(input bit rst, input bit sv, input bit ab, input bit ordy,
                     input step_sel_t sel, input int idx, input bit first,
                     input bit en, input bit ov, input bit sr);
    vec_t v;
    v.rst = rst; v.sv = sv; v.ab = ab; v.ordy = ordy;
    v.sel = sel; v.idx = step_idx_t'(idx);
    v.first = first; v.en = en; v.ov = ov; v.sr = sr;
    vecs.push_back(v);
  endtask

  // Inputs in the cycle before each listed step; the launch record is separate.
  task automatic add_steps(input bit sv_hold, input int from, input int upto);
    for (int k = from; k <= upto; k++)
      add(0, sv_hold, 0, 0, step_sel_t'(1) << k, k, 0, 1, 0, 0);
  endtask

  task automatic add_idle(input bit rst);
    add(rst, 0, 0, 0, '0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, i, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    reset           = 1'b1;
    bus.start_valid = 1'b0;
    bus.abort       = 1'b0;
    bus.out_ready   = 1'b0;

    // Reset, then a plain permutation with the result held for 5 cycles.
    add_idle(1);
    add_idle(0);
    add(0, 1, 0, 0, step_sel_t'(1), 0, 1, 1, 0, 0);
    add_steps(0, 1, NUM_STEPS - 1);
    add(0, 0, 0, 0, '0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, '0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, '0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, '0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, '0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, '0, 0, 0, 0, 0, 1);

    // Request held through RUN, then back-to-back launch from DONE.
    add(0, 1, 0, 0, step_sel_t'(1), 0, 1, 1, 0, 0);
    add_steps(1, 1, NUM_STEPS - 1);
    add(0, 1, 0, 0, '0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, step_sel_t'(1), 0, 1, 1, 0, 0);

    // Abort at step 5, then a start alongside abort in IDLE.
    add_steps(0, 1, 5);
    add(0, 0, 1, 0, '0, 0, 0, 0, 0, 1);
    add_idle(0);
    add(0, 1, 1, 0, step_sel_t'(1), 0, 1, 1, 0, 0);
    add_steps(0, 1, 7);

    // Reset at step 7, then reset while a result waits in DONE.
    add_idle(1);
    add_idle(0);
    add(0, 1, 0, 0, step_sel_t'(1), 0, 1, 1, 0, 0);
    add_steps(0, 1, NUM_STEPS - 1);
    add(0, 0, 0, 0, '0, 0, 0, 0, 1, 0);
    add_idle(1);
    add_idle(0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset           = vecs[i].rst;
      bus.start_valid = vecs[i].sv;
      bus.abort       = vecs[i].ab;
      bus.out_ready   = vecs[i].ordy;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("round_sel",   i, 32'(bus.round_sel),   32'(e.sel));
      chk("step_idx",    i, 32'(bus.step_idx),    32'(e.idx));
      chk("perm_first",  i, 32'(bus.perm_first),  32'(e.first));
      chk("perm_en",     i, 32'(bus.perm_en),     32'(e.en));
      chk("out_valid",   i, 32'(bus.out_valid),   32'(e.ov));
      chk("start_ready", i, 32'(bus.start_ready), 32'(e.sr));
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
